// File: rtl/mul_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Booth/Wallace multiplier.
package mul_pkg;

  localparam logic [1:0] MUL_OP_LO = 2'b00;
  localparam logic [1:0] MUL_OP_H  = 2'b01;
  localparam logic [1:0] MUL_OP_HU = 2'b10;

  localparam int MUL_STAGES        = 3;
  localparam int MUL_S1_CSA_LEVELS = 2;

  function automatic int mul_pp_count(input int width);
    return width / 2 + 1;
  endfunction

  // Rows left after applying `levels` rounds of 3:2 compression to n rows.
  function automatic int csa_rows(input int n, input int levels);
    int r;
    r = n;
    for (int l = 0; l < levels; l++) r = (r / 3) * 2 + r % 3;
    return r;
  endfunction

  function automatic int csa_depth(input int n);
    int r;
    int d;
    r = n;
    d = 0;
    while (r > 2) begin
      r = (r / 3) * 2 + r % 3;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/mul_pipe_booth_pp_gen.sv
// Radix-4 Booth recoder: one unaligned 2*WIDTH-bit partial product per recoded digit of b_ext.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0]   a_ext,
  input  logic [WIDTH+1:0]   b_ext,
  output logic [2*WIDTH-1:0] pp [mul_pp_count(WIDTH)]
);

  localparam int NPP = mul_pp_count(WIDTH);
  localparam int PW  = 2 * WIDTH;

  logic [PW-1:0]    a_1x;
  logic [PW-1:0]    a_2x;
  logic [WIDTH+2:0] b_pad;

  assign a_1x  = {{(PW - WIDTH - 2){a_ext[WIDTH+1]}}, a_ext};
  assign a_2x  = a_1x << 1;
  assign b_pad = {b_ext, 1'b0};

  function automatic logic [PW-1:0] booth_sel(input logic [2:0] t, input logic [PW-1:0] x1,
                                              input logic [PW-1:0] x2);
    case (t)
      3'b001, 3'b010: booth_sel = x1;
      3'b011:         booth_sel = x2;
      3'b100:         booth_sel = -x2;
      3'b101, 3'b110: booth_sel = -x1;
      default:        booth_sel = '0;
    endcase
  endfunction

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    assign pp[i] = booth_sel(b_pad[2*i+2 -: 3], a_1x, a_2x);
  end

endmodule

// File: rtl/mul_pipe.sv
// Three-stage Booth/Wallace multiplier: S1 recode + 2 CSA levels, S2 remaining CSA levels,
// S3 carry-propagate add and half selection driving the outputs.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               mul_clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NPP     = mul_pp_count(WIDTH);
  localparam int PW      = 2 * WIDTH;
  localparam int S1_ROWS = csa_rows(NPP, MUL_S1_CSA_LEVELS);
  localparam int DEPTH   = csa_depth(NPP);

  // Handshake: a beat transfers on a rising edge where valid & ready are both high; valid and
  // payload never depend on ready, and a stage refills in the same cycle it drains.
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic s3_adv;
  logic accept;

  assign s3_adv   = out_valid & out_ready;
  assign s2_adv   = s2_valid & (!out_valid | out_ready);
  assign s1_adv   = s1_valid & (!s2_valid | s2_adv);
  assign in_ready = !flush & (!s1_valid | s1_adv);
  assign accept   = in_valid & in_ready;

  // MUL also sign-extends: the low half is identical either way.
  logic             ext_signed;
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] b_ext;
  logic [PW-1:0]    pp [NPP];

  assign ext_signed = (in_op != MUL_OP_HU);
  assign a_ext      = {{2{ext_signed & in_a[WIDTH-1]}}, in_a};
  assign b_ext      = {{2{ext_signed & in_b[WIDTH-1]}}, in_b};

  booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
    .a_ext (a_ext),
    .b_ext (b_ext),
    .pp    (pp)
  );

  logic [PW-1:0]    s1_rows [S1_ROWS];
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [PW-1:0]    s2_sum;
  logic [PW-1:0]    s2_carry;
  logic [1:0]       s2_op;
  logic [TAG_W-1:0] s2_tag;

  // Level 0 is the aligned partial products; each further level is one 3:2 CSA row.
  // The level right after the S1 boundary reads the registered rows instead of the comb ones.
  for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
    localparam int CNT = csa_rows(NPP, l);
    logic [PW-1:0] row [CNT];
    if (l == 0) begin : g_src
      for (genvar j = 0; j < NPP; j++) begin : g_align
        assign row[j] = pp[j] << (2 * j);
      end
    end else begin : g_csa
      localparam int PREV = csa_rows(NPP, l - 1);
      localparam int GRP  = PREV / 3;
      logic [PW-1:0] src [PREV];
      if (l == MUL_S1_CSA_LEVELS + 1) begin : g_from_reg
        assign src = s1_rows;
      end else begin : g_from_comb
        assign src = g_lvl[l-1].row;
      end
      for (genvar g = 0; g < GRP; g++) begin : g_fa
        assign row[2*g]   = src[3*g] ^ src[3*g+1] ^ src[3*g+2];
        assign row[2*g+1] = ((src[3*g] & src[3*g+1]) | (src[3*g] & src[3*g+2]) |
                             (src[3*g+1] & src[3*g+2])) << 1;
      end
      for (genvar k = 0; k < PREV % 3; k++) begin : g_pass
        assign row[2*GRP+k] = src[3*GRP+k];
      end
    end
  end

  logic [PW-1:0] prod_sum;
  logic          sel_hi;

  assign prod_sum = s2_sum + s2_carry;
  assign sel_hi   = (s2_op == MUL_OP_H) | (s2_op == MUL_OP_HU);

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= accept | (s1_valid & !s1_adv);
      s2_valid  <= s1_adv | (s2_valid & !s2_adv);
      out_valid <= s2_adv | (out_valid & !s3_adv);
    end
  end

  // Data registers move only when their stage loads, so idle cycles do not toggle them.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < S1_ROWS; i++) s1_rows[i] <= '0;
      s1_op      <= MUL_OP_LO;
      s1_tag     <= '0;
      s2_sum     <= '0;
      s2_carry   <= '0;
      s2_op      <= MUL_OP_LO;
      s2_tag     <= '0;
      out_prod   <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (accept) begin
        s1_rows <= g_lvl[MUL_S1_CSA_LEVELS].row;
        s1_op   <= in_op;
        s1_tag  <= in_tag;
      end
      if (s1_adv) begin
        s2_sum   <= g_lvl[DEPTH].row[0];
        s2_carry <= g_lvl[DEPTH].row[1];
        s2_op    <= s1_op;
        s2_tag   <= s1_tag;
      end
      if (s2_adv) begin
        out_prod   <= prod_sum;
        out_result <= sel_hi ? prod_sum[PW-1:WIDTH] : prod_sum[WIDTH-1:0];
        out_tag    <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: directed vectors, streaming, backpressure, flush, reset,
// and random ops on a 32-bit and a 16-bit instance against a wide-integer reference.
module tb_mul_pipe;
  import mul_pkg::*;

  localparam int W    = 32;
  localparam int WH   = 16;
  localparam int TW   = 5;
  localparam int EW   = TW + W + 2 * W;
  localparam int EWH  = TW + WH + 2 * WH;
  localparam int NRND = 10000;

  // clock / reset
  logic mul_clk = 1'b0;
  logic resetn  = 1'b0;
  always #5 mul_clk = ~mul_clk;

  int cycle = 0;
  always @(posedge mul_clk) cycle <= cycle + 1;

  // 32-bit DUT
  logic            flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic            in_ready, out_valid;
  logic [1:0]      in_op = 2'b00;
  logic [W-1:0]    in_a = '0, in_b = '0, out_result;
  logic [TW-1:0]   in_tag = '0, out_tag;
  logic [2*W-1:0]  out_prod;

  mul_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
    .mul_clk(mul_clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_prod(out_prod), .out_tag(out_tag)
  );

  // 16-bit DUT
  logic            h_flush = 1'b0, h_in_valid = 1'b0, h_out_ready = 1'b1;
  logic            h_in_ready, h_out_valid;
  logic [1:0]      h_in_op = 2'b00;
  logic [WH-1:0]   h_in_a = '0, h_in_b = '0, h_out_result;
  logic [TW-1:0]   h_in_tag = '0, h_out_tag;
  logic [2*WH-1:0] h_out_prod;

  mul_pipe #(.WIDTH(WH), .TAG_W(TW)) u_dut16 (
    .mul_clk(mul_clk), .resetn(resetn), .flush(h_flush), .in_valid(h_in_valid),
    .in_ready(h_in_ready), .in_op(h_in_op), .in_a(h_in_a), .in_b(h_in_b), .in_tag(h_in_tag),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_result(h_out_result),
    .out_prod(h_out_prod), .out_tag(h_out_tag)
  );

  // scoreboard state
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            lat_check = 1'b0;
  logic [EW-1:0]  exp_q[$];
  logic [EWH-1:0] exp16_q[$];
  int             lat_q[$];
  logic [EW-1:0]  mon_e;
  logic [EWH-1:0] mon16_e;
  int             mon_lat;

  // hand-computed directed vectors
  localparam logic [1:0]     D_OP   [8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01};
  localparam logic [W-1:0]   D_A    [8] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                            32'hFFFFFFFF, 32'h00000002, 32'h80000000, 32'h80000000};
  localparam logic [W-1:0]   D_B    [8] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                            32'h00000003, 32'h00000003, 32'h00000002, 32'h7FFFFFFF};
  localparam logic [2*W-1:0] D_PROD [8] = '{64'h3FFFFFFF00000001, 64'h4000000000000000,
                                            64'h0000000000000001, 64'hFFFFFFFE00000001,
                                            64'hFFFFFFFFFFFFFFFD, 64'h0000000000000006,
                                            64'h0000000100000000, 64'hC000000080000000};
  localparam logic [W-1:0]   D_RES  [8] = '{32'h3FFFFFFF, 32'h40000000, 32'h00000000, 32'hFFFFFFFE,
                                            32'hFFFFFFFD, 32'h00000006, 32'h00000001, 32'hC0000000};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: extend both operands to 128 bits and multiply with plain integer arithmetic.
  function automatic logic [127:0] ref_prod(input int w, input logic [1:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb;
    ea = {64'b0, a};
    eb = {64'b0, b};
    if (op != 2'b10) begin
      if (a[w-1]) ea = ea | (~128'b0 << w);
      if (b[w-1]) eb = eb | (~128'b0 << w);
    end
    return (ea * eb) & (~128'b0 >> (128 - 2 * w));
  endfunction

  function automatic logic [EW-1:0] exp32(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [TW-1:0] tag);
    logic [127:0] p;
    p = ref_prod(W, op, {32'b0, a}, {32'b0, b});
    return {tag, (op == 2'b01 || op == 2'b10) ? p[2*W-1:W] : p[W-1:0], p[2*W-1:0]};
  endfunction

  function automatic logic [EWH-1:0] exp16(input logic [1:0] op, input logic [WH-1:0] a,
                                           input logic [WH-1:0] b, input logic [TW-1:0] tag);
    logic [127:0] p;
    p = ref_prod(WH, op, {48'b0, a}, {48'b0, b});
    return {tag, (op == 2'b01 || op == 2'b10) ? p[2*WH-1:WH] : p[WH-1:0], p[2*WH-1:0]};
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return ~64'h0;
      2:       return 64'h8000_0000_0000_8000;
      3:       return 64'h7FFF_FFFF_0000_7FFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // driver: hold the request until accepted (bounded), optionally scoreboard it
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [EW-1:0] exp, input bit push);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge mul_clk);
      if (in_ready) begin
        done = 1'b1;
        if (push) begin
          exp_q.push_back(exp);
          lat_q.push_back(cycle);
        end
      end
      @(posedge mul_clk); #1;
    end
    check("issue_accepted", 128'(done), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || exp16_q.size() != 0) && k < 300) begin
      @(posedge mul_clk); #1;
      k++;
    end
    check("drain_q32", 128'(exp_q.size()), 128'(0));
    check("drain_q16", 128'(exp16_q.size()), 128'(0));
  endtask

  task automatic rand_run32(input int n);
    int sent;
    int guard;
    logic [63:0] ra, rb;
    sent = 0;
    guard = 0;
    while (sent < n && guard < 60000) begin
      ra = rand_operand(); rb = rand_operand();
      in_valid = ($urandom_range(0, 3) != 0);
      in_op = 2'($urandom_range(0, 3)); in_a = ra[W-1:0]; in_b = rb[W-1:0];
      in_tag = TW'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge mul_clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(exp32(in_op, in_a, in_b, in_tag));
        lat_q.push_back(cycle);
        sent++;
      end
      @(posedge mul_clk); #1;
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand32_sent", 128'(sent), 128'(n));
  endtask

  task automatic rand_run16(input int n);
    int sent;
    int guard;
    logic [63:0] ra, rb;
    sent = 0;
    guard = 0;
    while (sent < n && guard < 60000) begin
      ra = rand_operand(); rb = rand_operand();
      h_in_valid = ($urandom_range(0, 3) != 0);
      h_in_op = 2'($urandom_range(0, 3)); h_in_a = ra[WH-1:0]; h_in_b = rb[WH-1:0];
      h_in_tag = TW'($urandom_range(0, 31));
      h_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge mul_clk);
      if (h_in_valid && h_in_ready) begin
        exp16_q.push_back(exp16(h_in_op, h_in_a, h_in_b, h_in_tag));
        sent++;
      end
      @(posedge mul_clk); #1;
      guard++;
    end
    h_in_valid = 1'b0; h_out_ready = 1'b1;
    check("rand16_sent", 128'(sent), 128'(n));
  endtask

  // monitors: compare the presented output every cycle it is valid, pop on transfer
  always @(negedge mul_clk) begin
    if (resetn && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid_tag", 128'(out_tag), 128'(1'b0) - 1);
      end else begin
        mon_e = exp_q[0];
        check("out_tag", 128'(out_tag), 128'(mon_e[EW-1:3*W]));
        check("out_result", 128'(out_result), 128'(mon_e[3*W-1:2*W]));
        check("out_prod", 128'(out_prod), 128'(mon_e[2*W-1:0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (lat_q.size() != 0) begin
            mon_lat = lat_q.pop_front();
            if (lat_check) check("latency", 128'(cycle - mon_lat), 128'(MUL_STAGES));
          end
        end
      end
    end
  end

  always @(negedge mul_clk) begin
    if (resetn && h_out_valid) begin
      if (exp16_q.size() == 0) begin
        check("unexpected_out_valid16_tag", 128'(h_out_tag), 128'(1'b0) - 1);
      end else begin
        mon16_e = exp16_q[0];
        check("out_tag16", 128'(h_out_tag), 128'(mon16_e[EWH-1:3*WH]));
        check("out_result16", 128'(h_out_result), 128'(mon16_e[3*WH-1:2*WH]));
        check("out_prod16", 128'(h_out_prod), 128'(mon16_e[2*WH-1:0]));
        if (h_out_ready) void'(exp16_q.pop_front());
      end
    end
  end

  initial begin : main
    int acc;
    // reset state
    #12;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_result", 128'(out_result), 128'(0));
    check("reset_out_prod", 128'(out_prod), 128'(0));
    check("reset_out_tag", 128'(out_tag), 128'(0));
    @(negedge mul_clk); resetn = 1'b1;
    @(negedge mul_clk);
    check("in_ready_after_reset", 128'(in_ready), 128'(1));
    @(posedge mul_clk); #1;

    // directed vectors back to back, latency checked
    lat_check = 1'b1;
    for (int i = 0; i < 8; i++)
      issue(D_OP[i], D_A[i], D_B[i], TW'(i), {TW'(i), D_RES[i], D_PROD[i]}, 1'b1);
    drain();

    // stream of 8 with out_ready high
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] sa, sb;
      logic [1:0]   so;
      sa = 32'hF000_0000 | W'(k * 37);
      sb = 32'h0000_1000 + W'(k * 1001);
      so = 2'(k);
      issue(so, sa, sb, TW'(8 + k), exp32(so, sa, sb, TW'(8 + k)), 1'b1);
    end
    drain();

    // backpressure: empty pipe takes exactly 3 ops, then in_ready drops
    lat_check = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_op = 2'b01; in_a = W'(32'h1111_0000 + k); in_b = W'(32'hFFFF_0000 - k);
      in_tag = TW'(16 + acc);
      @(negedge mul_clk);
      if (in_ready) begin
        exp_q.push_back(exp32(in_op, in_a, in_b, in_tag));
        lat_q.push_back(cycle);
        acc++;
      end
      @(posedge mul_clk); #1;
    end
    @(negedge mul_clk);
    check("bp_accepts", 128'(acc), 128'(3));
    check("bp_in_ready_low", 128'(in_ready), 128'(0));
    @(posedge mul_clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // flush: two ops killed, op in flush cycle refused, op after flush survives
    lat_check = 1'b1;
    issue(2'b00, 32'd5, 32'd7, TW'(20), '0, 1'b0);
    issue(2'b00, 32'd9, 32'd11, TW'(21), '0, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_a = 32'd13; in_b = 32'd17; in_tag = TW'(22);
    @(negedge mul_clk);
    check("flush_in_ready", 128'(in_ready), 128'(0));
    @(posedge mul_clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 128'(out_valid), 128'(0));
    issue(2'b10, 32'h0001_0000, 32'h0003_0000, TW'(23), {TW'(23), 32'h0000_0003, 64'h0000_0003_0000_0000}, 1'b1);
    drain();

    // reset with three ops in flight
    lat_check = 1'b0;
    issue(2'b01, 32'h1234_5678, 32'h8765_4321, TW'(24), '0, 1'b0);
    issue(2'b01, 32'h2345_6789, 32'h9876_5432, TW'(25), '0, 1'b0);
    issue(2'b01, 32'h3456_789A, 32'hA987_6543, TW'(26), '0, 1'b0);
    resetn = 1'b0;
    #1;
    check("midreset_out_valid", 128'(out_valid), 128'(0));
    check("midreset_out_prod", 128'(out_prod), 128'(0));
    repeat (2) @(posedge mul_clk);
    @(negedge mul_clk); resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge mul_clk);
      check("postreset_out_valid", 128'(out_valid), 128'(0));
    end
    @(posedge mul_clk); #1;

    // random ops on both widths with random backpressure
    fork
      rand_run32(NRND);
      rand_run16(NRND);
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, pipelined radix-4 Booth / Wallace-tree multiplier. Successor to the single-cycle 32-bit multiplier.
- Adds a WIDTH parameter, 3 register stages, valid/ready handshakes on both sides, op-mode result selection, tag passthrough and pipeline flush.
- Sits between the EXE-stage issue logic and the writeback mux of the CPU. Sustains one multiply per cycle.

Parameters:
- WIDTH, 32, operand width; even, 8..64.
- TAG_W, 5, width of the opaque tag carried with each op (destination register id).

Ports:
- mul_clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- flush  input  1  kill all in-flight ops (exception/branch cancel)
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- in_op  input  2  00 MUL (low half), 01 MULH (signed high), 10 MULHU (unsigned high), 11 reserved (treated as MUL)
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_tag  input  TAG_W  passthrough tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result when out_valid & out_ready
- out_result  output  WIDTH  selected half of the product
- out_prod  output  2*WIDTH  full product (signed or unsigned per op)
- out_tag  output  TAG_W  tag of the op on out_result

Behaviour:
- Reset: asynchronous on resetn low. All stage valid bits, out_valid, out_result, out_prod and out_tag are 0. in_ready is 1 once resetn is high.
- Signedness: signed = (op==MULH); MUL uses signed extension, which gives an identical low half.
- Operands are extended to WIDTH+2 bits: sign-extended if signed, zero-extended otherwise.
- Booth encoding gives WIDTH/2+1 partial products, each 2*WIDTH bits, selected from {0, +A, -A, +2A, -2A}. Partial product i is shifted left by 2i. Sum is modulo 2^(2*WIDTH).
- Stage S1 (registered): Booth encode, partial products, first two 3:2 CSA levels. op, tag and valid are registered alongside.
- Stage S2 (registered): remaining CSA levels down to a carry/sum pair.
- Stage S3 (registered, drives the outputs): carry-propagate add into out_prod, plus out_result selection.
  - MUL: out_result = prod[WIDTH-1:0].
  - Otherwise: out_result = prod[2W-1:W].
- Latency: out_valid rises exactly 3 cycles after acceptance if there is no backpressure. Throughput is 1 op/cycle.
- Advance rule, per stage k: stage k loads when stage k is empty or its contents advance this cycle.
  - S3 advances when out_ready is high.
  - in_ready = !flush & (S1 empty | S1 advances). Bubbles collapse.
- Backpressure: while out_valid & !out_ready, out_result, out_prod and out_tag are held stable. Upstream stages keep filling until full, then in_ready drops.
- Flush: synchronous. The next cycle all valid bits are 0, including out_valid.
  - in_ready is 0 during the flush cycle. in_valid in that cycle is not accepted.
  - Data registers are don't-care after flush.
- flush together with out_valid & out_ready in the same cycle: the output transfer counts as completed.
- Reset asserted mid-operation: all ops are lost and there are no spurious outputs after release.
- Data registers update only on load. This avoids switching on idle cycles.

Decomposition:
- Package mul_pkg holds:
  - op encodings MUL_OP_LO / MUL_OP_H / MUL_OP_HU;
  - a function giving the partial-product count, WIDTH/2+1;
  - the stage count constant MUL_STAGES = 3.
- Sub-module booth_pp_gen (combinational): inputs extended A and B; outputs an array of WIDTH/2+1 unaligned partial products.
- The 3:2 CSA row is an inline generate loop, not a separate module.

Test Plan (WIDTH=32):
- MULH 0x7FFFFFFF x 0x7FFFFFFF -> out_prod 0x3FFFFFFF00000001, out_result 0x3FFFFFFF, out_valid 3 cycles after accept.
- MULH 0x80000000 x 0x80000000 -> out_prod 0x4000000000000000. Then MULH 0xFFFFFFFF x 0xFFFFFFFF -> out_result 0x00000000, out_prod 0x1.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> out_prod 0xFFFFFFFE00000001, out_result 0xFFFFFFFE. MUL 0xFFFFFFFF x 0x00000003 -> out_result 0xFFFFFFFD.
- Back-to-back stream of 8 ops with out_ready=1 -> 8 consecutive out_valid cycles, tags in order. Then hold out_ready=0 for 5 cycles -> in_ready drops after 3 further accepts and outputs stay stable. Release -> no loss or duplication.
- Issue 2 ops, assert flush 1 cycle later -> no out_valid for those tags. An op issued the cycle after flush appears 3 cycles later with the correct value.
- Pull resetn low while 3 ops are in flight -> out_valid=0 immediately and stays 0 after release until a new accept. Then run 10k random signed/unsigned ops at WIDTH=16 and WIDTH=32 against a reference model.
